// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Purpose:
//   Moore-style sequencer for a multi-cycle RV32I datapath that shares one
//   memory for instructions and data (PC, OldPC, IR, ALUOut and MDR registers
//   live in the datapath). Each instruction runs through FETCH / DECODE /
//   EXEC / MEM / WB states. Memory states stretch until mem_ready. Supported
//   classes are R-type, I-type ALU, load, store and beq/bne. Any other
//   opcode or branch func3 lands in TRAP, which holds until reset.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   opcode[6:0]  in   IR[6:0]
//   func3[2:0]   in   IR[14:12]
//   zero         in   ALU zero flag
//   mem_ready    in   memory finishes the current MemRead/MemWrite this cycle
//   PCWrite      out  load PC
//   IRWrite      out  load IR and OldPC
//   IorD         out  memory address select: 0=PC, 1=ALUOut
//   MemRead      out  memory read request
//   MemWrite     out  memory write request
//   MemtoReg     out  register write data: 0=ALUOut, 1=MDR
//   RegWrite     out  write rd
//   ALUSrcA      out  0=PC/OldPC, 1=rs1
//   ALUSrcB[1:0] out  00=rs2, 01=constant 4, 10=immediate
//   ALUop        out  00=add, 01=sub, 10=R func decode, 11=I func decode
//   PCSrc        out  0=ALU result, 1=ALUOut
//   instr_done   out  one-cycle pulse in the last state of each instruction
//   err          out  high while in TRAP
//   dbg_state    out  current state encoding
//
// Parameters:
//   STATE_W      state register / dbg_state width (>= 4)
//   ALUOP_W      ALUop width (>= 2); bits above [1:0] are driven 0
//   MEM_TIMEOUT  maximum wait cycles per memory access (timeout build only)
//
// Configuration macro:
//   MC_BUS_TIMEOUT_EN  when defined, a wait counter forces TRAP once a memory
//                      access has waited MEM_TIMEOUT cycles without mem_ready.
//                      When undefined, memory waits are unbounded.
// ---------------------------------------------------------------------------
module multicycle_control #(
  parameter int STATE_W     = 4,
  parameter int ALUOP_W     = 2,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         opcode,
  input  logic [2:0]         func3,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUop,
  output logic               PCSrc,
  output logic               instr_done,
  output logic               err,
  output logic [STATE_W-1:0] dbg_state
);

  // RV32I major opcodes
  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_B_TYPE = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  // Elaboration-time sanity check of the parameters
  if (STATE_W < 4 || ALUOP_W < 2 || MEM_TIMEOUT < 1) begin : g_param_check
    $error("multicycle_control: STATE_W>=4, ALUOP_W>=2 and MEM_TIMEOUT>=1 required");
  end

  typedef enum logic [STATE_W-1:0] {
    IDLE     = STATE_W'(0),
    FETCH    = STATE_W'(1),
    DECODE   = STATE_W'(2),
    EXEC_R   = STATE_W'(3),
    EXEC_I   = STATE_W'(4),
    MEM_ADDR = STATE_W'(5),
    MEM_RD   = STATE_W'(6),
    MEM_WR   = STATE_W'(7),
    WB_ALU   = STATE_W'(8),
    WB_MEM   = STATE_W'(9),
    BRANCH   = STATE_W'(10),
    TRAP     = STATE_W'(11)
  } state_t;

  state_t state_q;
  state_t state_d;

  // High on the cycle a memory wait must give up and fall into TRAP
  logic timeout_hit;

`ifdef MC_BUS_TIMEOUT_EN
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_d;
  logic              in_wait_state;

  assign in_wait_state = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);

  // wait_q holds the number of already-elapsed wait cycles in the current
  // memory state, so the current cycle is wait number wait_q+1. A ready
  // memory on that cycle still wins over the timeout.
  assign timeout_hit = in_wait_state && !mem_ready && (wait_q == WAIT_LAST);

  // Any state change clears the counter; this covers entry into every
  // memory state, including MEM_WR -> FETCH back-to-back.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (in_wait_state && !mem_ready) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register; reset abandons any instruction in flight immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = FETCH;

      FETCH: begin
        if (mem_ready) begin
          state_d = DECODE;
        end else if (timeout_hit) begin
          state_d = TRAP;
        end
      end

      DECODE: begin
        if (opcode == OP_R_TYPE) begin
          state_d = EXEC_R;
        end else if (opcode == OP_I_TYPE) begin
          state_d = EXEC_I;
        end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
          state_d = MEM_ADDR;
        end else if (opcode == OP_B_TYPE && (func3 == F3_BEQ || func3 == F3_BNE)) begin
          state_d = BRANCH;
        end else begin
          state_d = TRAP;
        end
      end

      EXEC_R: state_d = WB_ALU;
      EXEC_I: state_d = WB_ALU;

      // IR still holds the instruction, so opcode is stable here
      MEM_ADDR: begin
        if (opcode == OP_LOAD) begin
          state_d = MEM_RD;
        end else if (opcode == OP_STORE) begin
          state_d = MEM_WR;
        end else begin
          state_d = TRAP;
        end
      end

      MEM_RD: begin
        if (mem_ready) begin
          state_d = WB_MEM;
        end else if (timeout_hit) begin
          state_d = TRAP;
        end
      end

      MEM_WR: begin
        if (mem_ready) begin
          state_d = FETCH;
        end else if (timeout_hit) begin
          state_d = TRAP;
        end
      end

      WB_ALU: state_d = FETCH;
      WB_MEM: state_d = FETCH;
      BRANCH: state_d = FETCH;
      TRAP:   state_d = TRAP;
      default: state_d = TRAP;
    endcase
  end

  // Output decode. Only the handshake-qualified strobes (PCWrite/IRWrite in
  // FETCH, instr_done in MEM_WR) and the branch decision look at inputs.
  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUop      = '0;
    PCSrc      = 1'b0;
    instr_done = 1'b0;
    err        = 1'b0;
    unique case (state_q)
      IDLE: ;

      // PC+4 computed while the instruction is read; IR, OldPC and PC load
      // together on the cycle the memory returns data
      FETCH: begin
        MemRead    = 1'b1;
        ALUSrcB    = 2'b01;
        IRWrite    = mem_ready;
        PCWrite    = mem_ready;
      end

      // Speculative branch target OldPC+imm parked in ALUOut
      DECODE: begin
        ALUSrcB    = 2'b10;
      end

      EXEC_R: begin
        ALUSrcA    = 1'b1;
        ALUop[1:0] = 2'b10;
      end

      EXEC_I: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUop[1:0] = 2'b11;
      end

      MEM_ADDR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
      end

      MEM_RD: begin
        MemRead    = 1'b1;
        IorD       = 1'b1;
      end

      MEM_WR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
      end

      WB_ALU: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end

      WB_MEM: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end

      // rs1-rs2 sets zero; taken branches load the target from ALUOut
      BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUop[1:0] = 2'b01;
        PCSrc      = 1'b1;
        PCWrite    = (func3 == F3_BEQ) ? zero : ~zero;
        instr_done = 1'b1;
      end

      TRAP: begin
        err        = 1'b1;
      end

      default: begin
        err        = 1'b1;
      end
    endcase
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//
// Directed bench for multicycle_control. Control outputs are packed into one
// 15-bit vector {PCWrite,IRWrite,IorD,MemRead,MemWrite,MemtoReg,RegWrite,
// ALUSrcA,ALUSrcB,ALUop,PCSrc,instr_done,err} and compared against
// hand-written per-state constants, together with dbg_state.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

  localparam int STATE_W = 4;
  localparam int ALUOP_W = 2;

  // Expected control vectors
  localparam logic [14:0] C_ZERO      = 15'b000000000000000;
  localparam logic [14:0] C_FETCH_RDY = 15'b110100000100000;
  localparam logic [14:0] C_FETCH_WT  = 15'b000100000100000;
  localparam logic [14:0] C_DECODE    = 15'b000000001000000;
  localparam logic [14:0] C_EXEC_R    = 15'b000000010010000;
  localparam logic [14:0] C_EXEC_I    = 15'b000000011011000;
  localparam logic [14:0] C_MEM_ADDR  = 15'b000000011000000;
  localparam logic [14:0] C_MEM_RD    = 15'b001100000000000;
  localparam logic [14:0] C_MEM_WR_WT = 15'b001010000000000;
  localparam logic [14:0] C_MEM_WR_OK = 15'b001010000000010;
  localparam logic [14:0] C_WB_ALU    = 15'b000000100000010;
  localparam logic [14:0] C_WB_MEM    = 15'b000001100000010;
  localparam logic [14:0] C_BR_TAKEN  = 15'b100000010001110;
  localparam logic [14:0] C_BR_NOT    = 15'b000000010001110;
  localparam logic [14:0] C_TRAP      = 15'b000000000000001;

  logic               clk;
  logic               rst_n;
  logic [6:0]         opcode;
  logic [2:0]         func3;
  logic               zero;
  logic               mem_ready;
  logic               PCWrite;
  logic               IRWrite;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               MemtoReg;
  logic               RegWrite;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [ALUOP_W-1:0] ALUop;
  logic               PCSrc;
  logic               instr_done;
  logic               err;
  logic [STATE_W-1:0] dbg_state;
  logic [14:0]        ctrl_obs;

  int checkCount;
  int errorCount;

  multicycle_control #(
    .STATE_W    (STATE_W),
    .ALUOP_W    (ALUOP_W),
    .MEM_TIMEOUT(15)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .func3     (func3),
    .zero      (zero),
    .mem_ready (mem_ready),
    .PCWrite   (PCWrite),
    .IRWrite   (IRWrite),
    .IorD      (IorD),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .MemtoReg  (MemtoReg),
    .RegWrite  (RegWrite),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUop     (ALUop),
    .PCSrc     (PCSrc),
    .instr_done(instr_done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  assign ctrl_obs = {PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegWrite,
                     ALUSrcA, ALUSrcB, ALUop, PCSrc, instr_done, err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                               input logic z, input logic rdy);
    opcode    = op;
    func3     = f3;
    zero      = z;
    mem_ready = rdy;
  endtask

  // Advance one clock and sample on the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic stepCheck(input string tag, input int exp_state, input logic [14:0] exp_ctrl);
    tick();
    checkOutput({tag, "_state"}, 32'(dbg_state), 32'(exp_state));
    checkOutput({tag, "_ctrl"}, 32'(ctrl_obs), 32'(exp_ctrl));
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst_n = 1'b0;
    applyStimulus(7'b0110011, 3'b000, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("rst_state", 32'(dbg_state), 32'd0);
    checkOutput("rst_ctrl", 32'(ctrl_obs), 32'(C_ZERO));

    // Release: IDLE -> FETCH on the first edge
    rst_n = 1'b1;
    stepCheck("rel_fetch", 1, C_FETCH_RDY);

    // R-type: 1,2,3,8 then back to FETCH
    stepCheck("r_decode", 2, C_DECODE);
    stepCheck("r_exec", 3, C_EXEC_R);
    stepCheck("r_wb", 8, C_WB_ALU);
    stepCheck("r_fetch", 1, C_FETCH_RDY);

    // I-type
    applyStimulus(7'b0010011, 3'b000, 1'b0, 1'b1);
    stepCheck("i_decode", 2, C_DECODE);
    stepCheck("i_exec", 4, C_EXEC_I);
    stepCheck("i_wb", 8, C_WB_ALU);
    stepCheck("i_fetch", 1, C_FETCH_RDY);

    // Load with three wait cycles in MEM_RD
    applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b1);
    stepCheck("ld_decode", 2, C_DECODE);
    stepCheck("ld_addr", 5, C_MEM_ADDR);
    mem_ready = 1'b0;
    stepCheck("ld_wait1", 6, C_MEM_RD);
    stepCheck("ld_wait2", 6, C_MEM_RD);
    stepCheck("ld_wait3", 6, C_MEM_RD);
    tick();
    mem_ready = 1'b1;
    checkOutput("ld_rdy_state", 32'(dbg_state), 32'd6);
    checkOutput("ld_rdy_ctrl", 32'(ctrl_obs), 32'(C_MEM_RD));
    stepCheck("ld_wb", 9, C_WB_MEM);
    stepCheck("ld_fetch", 1, C_FETCH_RDY);

    // Store completing immediately
    applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b1);
    stepCheck("st_decode", 2, C_DECODE);
    stepCheck("st_addr", 5, C_MEM_ADDR);
    stepCheck("st_wr", 7, C_MEM_WR_OK);
    stepCheck("st_fetch", 1, C_FETCH_RDY);

    // Store stalled, then reset mid-write
    stepCheck("st2_decode", 2, C_DECODE);
    stepCheck("st2_addr", 5, C_MEM_ADDR);
    mem_ready = 1'b0;
    stepCheck("st2_wait", 7, C_MEM_WR_WT);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midrst_memwrite", 32'(MemWrite), 32'd0);
    checkOutput("midrst_state", 32'(dbg_state), 32'd0);
    checkOutput("midrst_ctrl", 32'(ctrl_obs), 32'(C_ZERO));
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    stepCheck("midrst_fetch", 1, C_FETCH_RDY);

    // beq, zero=1 -> taken
    applyStimulus(7'b1100011, 3'b000, 1'b1, 1'b1);
    stepCheck("beq_decode", 2, C_DECODE);
    stepCheck("beq_branch", 10, C_BR_TAKEN);
    stepCheck("beq_fetch", 1, C_FETCH_RDY);

    // bne, zero=1 -> not taken
    applyStimulus(7'b1100011, 3'b001, 1'b1, 1'b1);
    stepCheck("bne1_decode", 2, C_DECODE);
    stepCheck("bne1_branch", 10, C_BR_NOT);
    stepCheck("bne1_fetch", 1, C_FETCH_RDY);

    // bne, zero=0 -> taken
    applyStimulus(7'b1100011, 3'b001, 1'b0, 1'b1);
    stepCheck("bne0_decode", 2, C_DECODE);
    stepCheck("bne0_branch", 10, C_BR_TAKEN);
    stepCheck("bne0_fetch", 1, C_FETCH_RDY);

    // Unsupported branch func3 -> TRAP
    applyStimulus(7'b1100011, 3'b010, 1'b0, 1'b1);
    stepCheck("bf3_decode", 2, C_DECODE);
    stepCheck("bf3_trap", 11, C_TRAP);

    // Illegal opcode -> TRAP, sticky for 20 cycles of changing inputs
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(7'b1111111, 3'b000, 1'b0, 1'b1);
    stepCheck("ill_fetch", 1, C_FETCH_RDY);
    stepCheck("ill_decode", 2, C_DECODE);
    stepCheck("ill_trap", 11, C_TRAP);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(7'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
      stepCheck("ill_hold", 11, C_TRAP);
    end
    #1 rst_n = 1'b0;
    #1;
    checkOutput("ill_clear_err", 32'(err), 32'd0);

    // Fetch with memory never ready
    applyStimulus(7'b0110011, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    stepCheck("fwait_first", 1, C_FETCH_WT);
`ifdef MC_BUS_TIMEOUT_EN
    for (int i = 1; i < 15; i++) begin
      stepCheck("to_waiting", 1, C_FETCH_WT);
    end
    stepCheck("to_trap", 11, C_TRAP);
`else
    for (int i = 0; i < 20; i++) begin
      stepCheck("nto_waiting", 1, C_FETCH_WT);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
